// File: rtl/i2s_tx_master.sv
// ----------------------------------------------------------------------------
// i2s_tx_master
//
// I2S / left-justified audio transmitter that runs on a single system clock
// and generates its own bit clock, word select and serial data. One stereo
// frame is accepted per handshake into a one-entry holding buffer. Each frame
// is serialised into two slots of SLOT_WIDTH bit periods: the left sample,
// MSB first, then zero padding, then the right sample and its padding. If no
// frame is buffered when a frame starts, an all-zero frame is sent and
// underrun pulses.
//
// Parameters
//   DATA_WIDTH  sample width per channel (2..SLOT_WIDTH)
//   SLOT_WIDTH  bit-clock periods per channel slot (>= DATA_WIDTH)
//   BCLK_DIV    clk cycles per bclk period (even, >= 2)
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   en           run request, sampled at frame boundaries
//   mode         0 = I2S (ws one bit early), 1 = left-justified; latched
//                at each frame load
//   s_valid      stereo frame available
//   s_ready      holding buffer can accept a frame
//   s_ldata      left sample
//   s_rdata      right sample
//   bclk         bit clock
//   ws           word select, 0 = left, 1 = right
//   sda          serial data, MSB first, changes when bclk falls
//   frame_start  one-clk pulse on each frame load
//   underrun     one-clk pulse when a frame loads with the buffer empty
//   dbg_state    current state of the sequencer (0 = IDLE, 1 = RUN)
//
// Handshake: a frame transfers on every rising clk edge where s_valid and
// s_ready are both high. s_valid must not depend on s_ready; s_ready may rise
// combinationally with a frame load (the buffer empties on that same edge),
// so a full buffer can be refilled in the cycle it is consumed.
// ----------------------------------------------------------------------------
module i2s_tx_master #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_ldata,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  bclk,
    output logic                  ws,
    output logic                  sda,
    output logic                  frame_start,
    output logic                  underrun,
    output logic                  dbg_state
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(BCLK_DIV);
    localparam int HALF_DIV   = BCLK_DIV / 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shreg;
    logic                    mode_q;

    // Holding buffer
    logic                    full;
    logic [DATA_WIDTH-1:0]   buf_l;
    logic [DATA_WIDTH-1:0]   buf_r;

    logic                    div_last;
    logic                    frame_end;
    logic                    load_now;
    logic                    handshake;
    logic [DIV_W-1:0]        div_inc;
    logic [CNT_W-1:0]        bit_inc;
    logic [FRAME_BITS-1:0]   load_word;

    // Word select for a given bit position within the frame. In I2S mode
    // ws leads the data by one bit, so it covers [SLOT-1, 2*SLOT-2].
    function automatic logic ws_for(input logic [CNT_W-1:0] b, input logic lj);
        if (lj) begin
            return b >= CNT_W'(SLOT_WIDTH);
        end
        return (b >= CNT_W'(SLOT_WIDTH - 1)) && (b <= CNT_W'(FRAME_BITS - 2));
    endfunction

    always_comb begin
        div_last  = (state == ST_RUN) && (div_cnt == DIV_W'(BCLK_DIV - 1));
        frame_end = div_last && (bit_cnt == CNT_W'(FRAME_BITS - 1));
        // A load happens when starting from IDLE or at a frame boundary,
        // in both cases only while en is high.
        load_now  = en && ((state == ST_IDLE) || frame_end);
        s_ready   = ~full | load_now;
        handshake = s_valid && s_ready;
        div_inc   = div_cnt + DIV_W'(1);
        bit_inc   = bit_cnt + CNT_W'(1);

        // Frame layout: {ldata, pad, rdata, pad}; all zeros on underrun.
        load_word = '0;
        if (full) begin
            load_word = (FRAME_BITS'(buf_l) << (FRAME_BITS - DATA_WIDTH))
                      | (FRAME_BITS'(buf_r) << (SLOT_WIDTH - DATA_WIDTH));
        end
    end

    assign dbg_state = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            mode_q      <= 1'b0;
            full        <= 1'b0;
            buf_l       <= '0;
            buf_r       <= '0;
            bclk        <= 1'b0;
            ws          <= 1'b0;
            sda         <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            // A handshake in the load cycle refills the entry being consumed,
            // so it wins over the clear.
            if (handshake) begin
                full  <= 1'b1;
                buf_l <= s_ldata;
                buf_r <= s_rdata;
            end else if (load_now) begin
                full  <= 1'b0;
            end

            if (load_now) begin
                // Outputs are registered from the next-state values so that
                // sda shows the left MSB in the first cycle of the frame.
                state       <= ST_RUN;
                shreg       <= load_word;
                mode_q      <= mode;
                frame_start <= 1'b1;
                underrun    <= ~full;
                div_cnt     <= '0;
                bit_cnt     <= '0;
                bclk        <= 1'b0;
                sda         <= load_word[FRAME_BITS-1];
                ws          <= ws_for('0, mode);
            end else begin
                case (state)
                    ST_IDLE: begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        bclk    <= 1'b0;
                        ws      <= 1'b0;
                        sda     <= 1'b0;
                    end
                    ST_RUN: begin
                        if (div_last) begin
                            // bclk falls here; sda and ws only move on this edge.
                            div_cnt <= '0;
                            bclk    <= 1'b0;
                            if (frame_end) begin
                                // en is low (otherwise load_now): stop cleanly.
                                state   <= ST_IDLE;
                                bit_cnt <= '0;
                                shreg   <= '0;
                                ws      <= 1'b0;
                                sda     <= 1'b0;
                            end else begin
                                bit_cnt <= bit_inc;
                                shreg   <= shreg << 1;
                                sda     <= shreg[FRAME_BITS-2];
                                ws      <= ws_for(bit_inc, mode_q);
                            end
                        end else begin
                            div_cnt <= div_inc;
                            bclk    <= (div_inc >= DIV_W'(HALF_DIV));
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_master.sv
// ----------------------------------------------------------------------------
// tb_i2s_tx_master
//
// Directed bench for i2s_tx_master at default parameters (16-bit samples,
// 32-bit slots, bclk = clk/4). Serial data and word select are collected on
// every bclk rising edge and compared against hand-computed frames.
// ----------------------------------------------------------------------------
module tb_i2s_tx_master;

    localparam int DW = 16;
    localparam int SW = 32;
    localparam int BD = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          mode;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_ldata;
    logic [DW-1:0] s_rdata;
    logic          bclk;
    logic          ws;
    logic          sda;
    logic          frame_start;
    logic          underrun;
    logic          dbg_state;

    longint        cyc = 0;
    int            checks = 0;
    int            passes = 0;
    int            fails  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_tx_master #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .BCLK_DIV   (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_ldata     (s_ldata),
        .s_rdata     (s_rdata),
        .bclk        (bclk),
        .ws          (ws),
        .sda         (sda),
        .frame_start (frame_start),
        .underrun    (underrun),
        .dbg_state   (dbg_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver / collector ----------------
    // Samples at every falling clk edge. Records sda/ws at each bclk rise
    // (bit i goes to position 63-i), counts pulses and upcoming handshakes,
    // flags sda/ws moving outside a bclk fall or frame load, and measures the
    // bclk period. Optionally drops s_valid after the first cycle, advances
    // streaming data after each handshake, and drops en after bit en_off_at.
    task automatic capture(input bit drop_valid, input bit stream, input int max_bits,
                           input int en_off_at,
                           output logic [63:0] d, output logic [63:0] w,
                           output int fs_cnt, output int ur_cnt, output int hs_cnt,
                           output int bad_cnt, output int per_min, output int per_max,
                           output longint fs_cyc, output bit timeout);
        int   rises;
        int   n;
        int   last_rise;
        logic pb, ps, pw;
        bit   pend;
        rises = 0; n = 0; last_rise = -1;
        d = '0; w = '0;
        fs_cnt = 0; ur_cnt = 0; hs_cnt = 0; bad_cnt = 0;
        per_min = 1000; per_max = 0; fs_cyc = 0; timeout = 1'b0;
        #1;
        pend = s_valid && s_ready;
        pb = bclk; ps = sda; pw = ws;
        while (rises < max_bits && !timeout) begin
            @(negedge clk);
            n++;
            if (frame_start) begin
                fs_cnt++;
                fs_cyc = cyc;
            end
            if (underrun) begin
                ur_cnt++;
                if (!frame_start) bad_cnt++;
            end
            if ((sda !== ps || ws !== pw) && !(pb && !bclk) && !frame_start) bad_cnt++;
            if (bclk && !pb) begin
                d[63-rises] = sda;
                w[63-rises] = ws;
                if (last_rise >= 0) begin
                    if (n - last_rise < per_min) per_min = n - last_rise;
                    if (n - last_rise > per_max) per_max = n - last_rise;
                end
                last_rise = n;
                if (rises == en_off_at) en = 1'b0;
                rises++;
            end
            pb = bclk; ps = sda; pw = ws;
            if (stream && pend) begin
                s_ldata = s_ldata + 16'd1;
                s_rdata = s_rdata + 16'd1;
            end
            if (n == 1 && drop_valid) s_valid = 1'b0;
            #1;
            pend = s_valid && s_ready;
            if (pend) hs_cnt++;
            if (n >= 400) timeout = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] d, w;
        int          fsn, urn, hsn, bad, pmin, pmax, zero_bad;
        longint      fcyc, prev_fcyc;
        bit          tmo;

        // Reset with s_valid asserted
        rst = 1'b1; en = 1'b0; mode = 1'b1; s_valid = 1'b1;
        s_ldata = 16'hA5F0; s_rdata = 16'h0F0F;
        repeat (3) @(negedge clk);
        check("rst_bclk", bclk, 0);
        check("rst_ws", ws, 0);
        check("rst_sda", sda, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", s_ready, 1);
        @(negedge clk);
        check("ready_when_full_idle", s_ready, 0);

        // Left-justified frame; the same frame is re-offered so the next one repeats it
        en = 1'b1;
        capture(1'b1, 1'b0, 64, -1, d, w, fsn, urn, hsn, bad, pmin, pmax, fcyc, tmo);
        check("lj_timeout", tmo, 0);
        check("lj_sda", d, 64'hA5F0_0000_0F0F_0000);
        check("lj_ws", w, 64'h0000_0000_FFFF_FFFF);
        check("lj_frame_start", fsn, 1);
        check("lj_underrun", urn, 0);
        check("lj_period_min", pmin, 4);
        check("lj_period_max", pmax, 4);
        check("lj_stable", bad, 0);

        // Mode switched during the last bit; takes effect at the next load
        mode = 1'b0;
        capture(1'b0, 1'b0, 64, -1, d, w, fsn, urn, hsn, bad, pmin, pmax, fcyc, tmo);
        check("i2s_timeout", tmo, 0);
        check("i2s_sda", d, 64'hA5F0_0000_0F0F_0000);
        check("i2s_ws", w, 64'h0000_0001_FFFF_FFFE);
        check("i2s_frame_start", fsn, 1);
        check("i2s_underrun", urn, 0);
        check("i2s_stable", bad, 0);
        prev_fcyc = fcyc;

        // Underrun: no data offered for three frames
        for (int k = 0; k < 3; k++) begin
            capture(1'b0, 1'b0, 64, -1, d, w, fsn, urn, hsn, bad, pmin, pmax, fcyc, tmo);
            check("ur_timeout", tmo, 0);
            check("ur_sda", d, 64'h0);
            check("ur_frame_start", fsn, 1);
            check("ur_underrun", urn, 1);
            check("ur_alone_or_unstable", bad, 0);
            check("ur_spacing", fcyc - prev_fcyc, 256);
            prev_fcyc = fcyc;
        end

        // Streaming: s_valid held high, data incrementing from 1
        s_valid = 1'b1; s_ldata = 16'h0001; s_rdata = 16'h1001;
        for (int k = 0; k < 3; k++) begin
            capture(1'b0, 1'b1, 64, -1, d, w, fsn, urn, hsn, bad, pmin, pmax, fcyc, tmo);
            check("stream_timeout", tmo, 0);
            check("stream_left", d[63:48], 64'(k + 1));
            check("stream_right", d[31:16], 64'(16'h1001 + k));
            check("stream_handshakes", hsn, 1);
            check("stream_underrun", urn, 0);
            check("stream_spacing", fcyc - prev_fcyc, 256);
            prev_fcyc = fcyc;
        end

        // Stop: en dropped after bit 10, frame completes then stays quiet
        capture(1'b0, 1'b1, 64, 10, d, w, fsn, urn, hsn, bad, pmin, pmax, fcyc, tmo);
        check("stop_timeout", tmo, 0);
        check("stop_left", d[63:48], 64'h4);
        check("stop_right", d[31:16], 64'h1004);
        check("stop_stable", bad, 0);
        @(negedge clk);
        zero_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bclk || ws || sda || frame_start || underrun || dbg_state) zero_bad++;
        end
        check("stop_quiet", zero_bad, 0);
        check("stop_buffer_kept", s_ready, 0);

        // Restart (buffer holds 5), refill with 7777, then reset after bit 10
        en = 1'b1; s_valid = 1'b1; s_ldata = 16'h7777; s_rdata = 16'h7777;
        capture(1'b1, 1'b0, 11, -1, d, w, fsn, urn, hsn, bad, pmin, pmax, fcyc, tmo);
        check("rstrun_timeout", tmo, 0);
        check("rstrun_frame_start", fsn, 1);
        check("rstrun_underrun", urn, 0);
        check("rstrun_left_head", d[63:53], 64'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {bclk, ws, sda, frame_start, underrun, dbg_state}, 0);
        rst = 1'b0; s_valid = 1'b0;
        capture(1'b0, 1'b0, 64, -1, d, w, fsn, urn, hsn, bad, pmin, pmax, fcyc, tmo);
        check("restart_timeout", tmo, 0);
        check("restart_sda", d, 64'h0);
        check("restart_frame_start", fsn, 1);
        check("restart_underrun", urn, 1);
        en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
